seq_tx_1011: RTL and testbench

Serial bit-stream transmitter. It is the driving end of the 1011 sequence-detector interface.
- Accepts parallel frames over a valid/ready handshake and shifts them out one bit per clock, MSB first.
- Runs an internal reference model of an overlapping 1011 detector on the emitted stream. It flags and counts every 1011 occurrence, giving the bench a golden seq_seen to compare against.
- Sits between the test/stimulus source and any serial-input block, such as the detector.

---
 rtl/seq_tx_1011.sv | 154 +++++++++++++++
 tb/tb_seq_tx_1011.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_1011.sv
// seq_tx_1011 -- serial bit-stream transmitter for the 1011 detector interface.
//
// Accepts WIDTH-bit frames over a valid/ready handshake and shifts them onto
// out_bit one bit per clock (MSB first by default). A reference model of an
// overlapping 1011 detector watches the emitted line every clock, so
// expect_seen is cycle-aligned with a detector wired directly to out_bit.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   load_valid   frame offered
//   load_data    frame contents (sampled only on the transfer edge)
//   load_ready   transmitter can take a frame this cycle (combinational)
//   out_bit      serial data
//   out_valid    out_bit carries frame data this cycle
//   busy         frame in flight
//   expect_seen  model's seq_seen
//   match_count  saturating count of 1011 occurrences on the line
//
// Build option:
//   SEQ_TX_LSB_FIRST_EN  when defined, frames are shifted LSB first.

module seq_tx_1011 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             expect_seen,
    output logic [CNT_W-1:0] match_count
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_1    = 3'd1;
    localparam logic [2:0] M_10   = 3'd2;
    localparam logic [2:0] M_101  = 3'd3;
    localparam logic [2:0] M_1011 = 3'd4;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       model_q, model_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             xfer;

    function automatic logic [2:0] model_next(input logic [2:0] m, input logic b);
        logic [2:0] n;
        case (m)
            M_IDLE:  n = b ? M_1    : M_IDLE;
            M_1:     n = b ? M_1    : M_10;
            M_10:    n = b ? M_101  : M_IDLE;
            M_101:   n = b ? M_1011 : M_10;
            M_1011:  n = b ? M_1    : M_10;
            default: n = M_IDLE;
        endcase
        return n;
    endfunction

    // Ready on the last bit too, so a waiting frame follows with no gap.
    assign load_ready = reset && ((state_q == S_IDLE) || (bitcnt_q == LAST_BIT));
    assign xfer       = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;

        if (xfer) begin
            // The first bit goes straight to the output register; the shift
            // register holds only the bits still to come.
            state_d     = S_SHIFT;
            bitcnt_d    = '0;
            out_valid_d = 1'b1;
`ifdef SEQ_TX_LSB_FIRST_EN
            out_bit_d   = load_data[0];
            shreg_d     = load_data >> 1;
`else
            out_bit_d   = load_data[WIDTH-1];
            shreg_d     = load_data << 1;
`endif
        end else if (state_q == S_SHIFT) begin
            if (bitcnt_q == LAST_BIT) begin
                state_d     = S_IDLE;
                bitcnt_d    = '0;
                shreg_d     = '0;
                out_bit_d   = 1'b0;
                out_valid_d = 1'b0;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
`ifdef SEQ_TX_LSB_FIRST_EN
                out_bit_d = shreg_q[0];
                shreg_d   = shreg_q >> 1;
`else
                out_bit_d = shreg_q[WIDTH-1];
                shreg_d   = shreg_q << 1;
`endif
            end
        end
    end

    // The model sees the registered line value, exactly like a wired detector,
    // including the zeros driven while idle.
    always_comb begin
        model_d = model_next(model_q, out_bit_q);
        count_d = count_q;
        if ((model_d == M_1011) && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            model_q     <= M_IDLE;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            model_q     <= model_d;
            count_q     <= count_d;
        end
    end

    assign out_bit     = out_bit_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q == S_SHIFT);
    assign expect_seen = (model_q == M_1011);
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_tx_1011.sv
// Testbench for seq_tx_1011: directed steps with a scoreboard of expected
// line bits and a history-based 1011 reference.
module tb_seq_tx_1011;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MC_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             expect_seen;
    logic [CNT_W-1:0] match_count;

    seq_tx_1011 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .busy       (busy),
        .expect_seen(expect_seen),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic       exp_q[$];
    logic [3:0] hist = 4'b0;
    int         mc = 0;
    logic       exp_line = 1'b0;
    logic       exp_vld = 1'b0;
    logic       last_xfer = 1'b0;
    int         vld_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshake before the edge, advance the model at the
    // edge, compare outputs just after it.
    task automatic tick();
        logic             rst_s;
        logic             xfer;
        logic [WIDTH-1:0] xdata;
        @(negedge clk);
        rst_s = reset;
        xfer  = reset && load_valid && load_ready;
        xdata = load_data;
        chk("load_ready", 32'(load_ready), 32'(reset && (exp_q.size() == 0)));
        @(posedge clk);
        #1;
        if (!rst_s) begin
            hist = 4'b0;
            mc   = 0;
            exp_q.delete();
        end else begin
            hist = {hist[2:0], exp_line};
            if (hist == 4'b1011 && mc < MC_MAX) mc++;
            if (xfer) begin
`ifdef SEQ_TX_LSB_FIRST_EN
                for (int i = 0; i < WIDTH; i++) exp_q.push_back(xdata[i]);
`else
                for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(xdata[i]);
`endif
            end
        end
        if (exp_q.size() > 0) begin
            exp_line = exp_q.pop_front();
            exp_vld  = 1'b1;
        end else begin
            exp_line = 1'b0;
            exp_vld  = 1'b0;
        end
        chk("out_bit", 32'(out_bit), 32'(exp_line));
        chk("out_valid", 32'(out_valid), 32'(exp_vld));
        chk("busy", 32'(busy), 32'(exp_vld));
        chk("expect_seen", 32'(expect_seen), 32'(hist == 4'b1011));
        chk("match_count", 32'(match_count), 32'(mc));
        if (out_valid === 1'b1) vld_seen++;
        last_xfer = xfer;
    endtask

    task automatic wait_xfer();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_xfer && n < 40);
        chk("xfer_done", 32'(last_xfer), 32'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        wait_xfer();
        load_valid = 1'b0;
        load_data  = 8'hA5;   // changes after the transfer must not matter
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(match_count), 32'd0);
        reset = 1'b1;
        tick();

`ifdef SEQ_TX_LSB_FIRST_EN
        send(8'h0D);
        idle(9);
        chk("lsb_0d_count", 32'(match_count), 32'd1);
`else
        // Basic frame
        send(8'hB0);
        idle(9);
        chk("b0_count", 32'(match_count), 32'd1);
        chk("b0_idle_valid", 32'(out_valid), 32'd0);

        // Overlapping matches
        do_reset();
        send(8'h5B);
        idle(9);
        chk("5b_count", 32'(match_count), 32'd2);

        // Back-to-back frames with a cross-boundary match
        do_reset();
        vld_seen   = 0;
        load_valid = 1'b1;
        load_data  = 8'h01;
        wait_xfer();
        load_data  = 8'h60;
        wait_xfer();
        load_valid = 1'b0;
        idle(10);
        chk("b2b_valid_cycles", 32'(vld_seen), 32'd16);
        chk("b2b_count", 32'(match_count), 32'd1);

        // Saturation
        do_reset();
        repeat (8) send(8'hBB);
        idle(9);
        chk("sat_count", 32'(match_count), 32'd15);
        repeat (2) send(8'hBB);
        idle(9);
        chk("sat_hold", 32'(match_count), 32'd15);

        // Reset mid-frame
        do_reset();
        send(8'hB0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_seen", 32'(expect_seen), 32'd0);
        chk("midrst_count", 32'(match_count), 32'd0);
        reset = 1'b1;
        idle(2);
        send(8'h0B);
        idle(9);
        chk("0b_count", 32'(match_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
